// File: rtl/sting_pkg.sv
// Shared AXI constants and the read-address FSM state type for the sting
// input-feature read path.
package sting_pkg;

    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [12:0] AXI_4K_BYTES   = 13'd4096;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_CALC  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_DRAIN = 3'd3,
        RD_DONE  = 3'd4
    } rd_ag_state_t;

endpackage

// File: rtl/sting_rd_addr_gen_if.sv
// AXI4 read-address channel plus the R-channel signals the address generator
// watches to retire bursts.
interface sting_rd_addr_gen_if;

    // AR: a transfer happens on a rising edge where arvalid and arready are both
    // high; once raised, arvalid and its payload hold until that edge.
    // R is watched only: a burst retires on an edge with rvalid, rready, rlast high.
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        m_axi_rlast;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast
    );

endinterface

// File: rtl/sting_burst_len.sv
// Burst length for one AR: the smallest of MAX_BURST, words left in the line
// and words up to the next 4 KB boundary. Returned as AXI arlen (beats - 1).
module sting_burst_len
    import sting_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] addr_lo_i,
    input  logic [15:0] words_left_i,
    output logic [7:0]  arlen_o
);

    logic [12:0] to_4k_bytes;
    logic [15:0] to_4k_words;
    logic [15:0] len;

    always_comb begin
        // Address is word aligned, so this is always 1..1024 words.
        to_4k_bytes = AXI_4K_BYTES - {1'b0, addr_lo_i};
        to_4k_words = 16'(to_4k_bytes >> 2);
        len         = 16'(MAX_BURST);
        if (words_left_i < len) begin
            len = words_left_i;
        end
        if (to_4k_words < len) begin
            len = to_4k_words;
        end
        arlen_o = 8'(len - 16'd1);
    end

endmodule

// File: rtl/sting_rd_addr_gen.sv
// Input-feature read address generator: walks ysize lines of xsize words,
// issues INCR AR bursts and counts rlast completions until the job drains.
module sting_rd_addr_gen
    import sting_pkg::*;
#(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [31:0]          reg_axi_rd_input_start_adr,
    input  logic [15:0]          reg_axi_rd_input_xsize,
    input  logic [15:0]          reg_axi_rd_input_ysize,
    sting_rd_addr_gen_if.master  axi,
    output logic                 busy,
    output logic                 done,
    output rd_ag_state_t         dbg_state_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

    rd_ag_state_t     state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [15:0]      words_left_q, words_left_d;
    logic [15:0]      lines_left_q, lines_left_d;
    logic [15:0]      xsize_q, xsize_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic [7:0]       calc_arlen;
    logic [15:0]      beats;
    logic             ar_hs;
    logic             r_retire;

    sting_burst_len #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_len (
        .addr_lo_i    (addr_q[11:0]),
        .words_left_i (words_left_q),
        .arlen_o      (calc_arlen)
    );

    assign beats    = {8'd0, arlen_q} + 16'd1;
    assign ar_hs    = axi.m_axi_arvalid && axi.m_axi_arready;
    // A stray rlast with nothing in flight is dropped rather than underflowing.
    assign r_retire = axi.m_axi_rvalid && axi.m_axi_rready && axi.m_axi_rlast &&
                      (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (ar_hs && !r_retire) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!ar_hs && r_retire) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        lines_left_d = lines_left_q;
        xsize_d      = xsize_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    if (reg_axi_rd_input_xsize == 16'd0 || reg_axi_rd_input_ysize == 16'd0) begin
                        state_d = RD_DONE;
                    end else begin
                        state_d      = RD_CALC;
                        addr_d       = reg_axi_rd_input_start_adr & ~32'd3;
                        xsize_d      = reg_axi_rd_input_xsize;
                        words_left_d = reg_axi_rd_input_xsize;
                        lines_left_d = reg_axi_rd_input_ysize;
                    end
                end
            end
            RD_CALC: begin
                if (out_cnt_q < MAX_OUT_C) begin
                    state_d  = RD_ISSUE;
                    araddr_d = addr_q;
                    arlen_d  = calc_arlen;
                end
            end
            RD_ISSUE: begin
                if (axi.m_axi_arready) begin
                    // Lines are packed, so the next line starts where this one ended.
                    addr_d = addr_q + {14'd0, beats, 2'b00};
                    if (words_left_q == beats) begin
                        words_left_d = xsize_q;
                        lines_left_d = lines_left_q - 16'd1;
                        state_d      = (lines_left_q == 16'd1) ? RD_DRAIN : RD_CALC;
                    end else begin
                        words_left_d = words_left_q - beats;
                        state_d      = RD_CALC;
                    end
                end
            end
            RD_DRAIN: begin
                if (out_cnt_q == '0) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= RD_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
            xsize_q      <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            out_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            lines_left_q <= lines_left_d;
            xsize_q      <= xsize_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    assign axi.m_axi_arvalid = (state_q == RD_ISSUE);
    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arlen   = arlen_q;
    assign axi.m_axi_arsize  = AXI_SIZE_4B;
    assign axi.m_axi_arburst = AXI_BURST_INCR;
    assign busy              = (state_q == RD_CALC) || (state_q == RD_ISSUE) ||
                               (state_q == RD_DRAIN);
    assign done              = (state_q == RD_DONE);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_sting_rd_addr_gen.sv
// Self-checking bench for sting_rd_addr_gen: AR scoreboard, R responder with
// hold/release control, reset, backpressure and zero-size scenarios.
module tb_sting_rd_addr_gen;
    import sting_pkg::*;

    localparam int BIG = 1 << 30;

    logic         aclk;
    logic         areset;
    logic         start;
    logic [31:0]  start_adr;
    logic [15:0]  xsize;
    logic [15:0]  ysize;
    logic         busy;
    logic         done;
    rd_ag_state_t dbg_state;

    sting_rd_addr_gen_if axi_if ();

    sting_rd_addr_gen #(
        .MAX_BURST       (16),
        .MAX_OUTSTANDING (4)
    ) dut (
        .aclk                       (aclk),
        .areset                     (areset),
        .start                      (start),
        .reg_axi_rd_input_start_adr (start_adr),
        .reg_axi_rd_input_xsize     (xsize),
        .reg_axi_rd_input_ysize     (ysize),
        .axi                        (axi_if),
        .busy                       (busy),
        .done                       (done),
        .dbg_state_o                (dbg_state)
    );

    // clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: expected {araddr, arlen}
    logic [39:0] exp_q[$];
    logic [39:0] exp_ar;
    int          rd_ptr = 0;

    // monitor state (written only by the monitor)
    logic [31:0] obs_addr [0:511];
    logic [7:0]  obs_len  [0:511];
    int          obs_wr      = 0;
    int          hs_count    = 0;
    int          ret_count   = 0;
    int          done_count  = 0;
    int          peak_flight = 0;

    // responder control
    int r_limit = BIG;
    int r_sent  = 0;

    // Inputs are stable around negedge, so a handshake seen here lands on the next posedge.
    always @(negedge aclk) begin
        if (axi_if.m_axi_arvalid && axi_if.m_axi_arready) begin
            obs_addr[obs_wr % 512] = axi_if.m_axi_araddr;
            obs_len[obs_wr % 512]  = axi_if.m_axi_arlen;
            obs_wr++;
            hs_count++;
        end
        if (axi_if.m_axi_rvalid && axi_if.m_axi_rready && axi_if.m_axi_rlast) begin
            ret_count++;
        end
        if (hs_count - ret_count > peak_flight) peak_flight = hs_count - ret_count;
        if (done) done_count++;
    end

    // R responder: one rlast beat per issued AR, gated by r_limit
    always @(posedge aclk) begin
        #2;
        if ((hs_count - r_sent) > 0 && r_sent < r_limit) begin
            axi_if.m_axi_rvalid = 1'b1;
            axi_if.m_axi_rready = 1'b1;
            axi_if.m_axi_rlast  = 1'b1;
            r_sent++;
        end else begin
            axi_if.m_axi_rvalid = 1'b0;
            axi_if.m_axi_rready = 1'b0;
            axi_if.m_axi_rlast  = 1'b0;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic start_job(input logic [31:0] base, input logic [15:0] x, input logic [15:0] y);
        tick(1);
        start     = 1'b1;
        start_adr = base;
        xsize     = x;
        ysize     = y;
        tick(1);
        start     = 1'b0;
        start_adr = $urandom();
        xsize     = 16'($urandom());
        ysize     = 16'($urandom());
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int c = 0; c < budget; c++) begin
            tick(1);
            if (done_count != d0) break;
        end
        tick(3);
    endtask

    task automatic push_model(input logic [31:0] base, input int x, input int y);
        logic [31:0] a;
        int left, len, to4k;
        a = base & 32'hFFFF_FFFC;
        for (int l = 0; l < y; l++) begin
            left = x;
            while (left > 0) begin
                to4k = (4096 - int'(a[11:0])) / 4;
                len  = 16;
                if (left < len) len = left;
                if (to4k < len) len = to4k;
                exp_q.push_back({a, 8'(len - 1)});
                a    = a + 32'(len * 4);
                left = left - len;
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        start = 1'b0; start_adr = '0; xsize = '0; ysize = '0;
        axi_if.m_axi_arready = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({axi_if.m_axi_arvalid, axi_if.m_axi_araddr, axi_if.m_axi_arlen, busy, done} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: arvalid=%b araddr=%h arlen=%0d busy=%b done=%b, required all 0",
                     axi_if.m_axi_arvalid, axi_if.m_axi_araddr, axi_if.m_axi_arlen, busy, done);
        end
        n_checks++;
        if (dbg_state !== RD_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, RD_IDLE);
        end
        n_checks++;
        if (axi_if.m_axi_arsize !== 3'b010 || axi_if.m_axi_arburst !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_consts: arsize=%b arburst=%b, required 010/01",
                     axi_if.m_axi_arsize, axi_if.m_axi_arburst);
        end
        tick(1);
        areset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_count;
        for (int k = 0; k < 16; k++) exp_q.push_back({32'h8000_0000 + 32'(64 * k), 8'd15});
        start_job(32'h8000_0000, 16'd128, 16'd2);
        @(negedge aclk);
        n_checks++;
        if (busy !== 1'b1 || axi_if.m_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first_cycle: busy=%b arvalid=%b, required 1/0", busy, axi_if.m_axi_arvalid);
        end
        @(negedge aclk);
        n_checks++;
        if (axi_if.m_axi_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_arvalid_latency: arvalid=%b, required 1", axi_if.m_axi_arvalid);
        end
        wait_done(d0, 500);
        while (exp_q.size() > 0) begin
            exp_ar = exp_q.pop_front();
            n_checks++;
            if (rd_ptr >= obs_wr) begin
                n_fail++;
                $display("FAIL basic_ar: no AR seen, required addr=%h len=%0d", exp_ar[39:8], exp_ar[7:0]);
            end else begin
                if ({obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512]} !== exp_ar) begin
                    n_fail++;
                    $display("FAIL basic_ar: got addr=%h len=%0d, required addr=%h len=%0d",
                             obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512], exp_ar[39:8], exp_ar[7:0]);
                end
                rd_ptr++;
            end
        end
        n_checks++;
        if (rd_ptr != obs_wr) begin
            n_fail++;
            $display("FAIL basic_extra_ar: got %0d extra ARs, required 0", obs_wr - rd_ptr);
            rd_ptr = obs_wr;
        end
        n_checks++;
        if (done_count - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d done pulses, required 1", done_count - d0);
        end
        n_checks++;
        if (peak_flight > 4) begin
            n_fail++;
            $display("FAIL basic_outstanding: peak %0d in flight, required <= 4", peak_flight);
        end
    endtask

    // Fixed-vector jobs: 4 KB split and per-line split.
    task automatic test_split(input logic [31:0] base, input logic [15:0] x, input logic [15:0] y,
                              input int n, input logic [39:0] v0, input logic [39:0] v1,
                              input logic [39:0] v2, input logic [39:0] v3);
        int d0;
        d0 = done_count;
        exp_q.push_back(v0);
        exp_q.push_back(v1);
        if (n > 2) begin
            exp_q.push_back(v2);
            exp_q.push_back(v3);
        end
        start_job(base, x, y);
        wait_done(d0, 300);
        while (exp_q.size() > 0) begin
            exp_ar = exp_q.pop_front();
            n_checks++;
            if (rd_ptr >= obs_wr) begin
                n_fail++;
                $display("FAIL split_ar: no AR seen, required addr=%h len=%0d", exp_ar[39:8], exp_ar[7:0]);
            end else begin
                if ({obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512]} !== exp_ar) begin
                    n_fail++;
                    $display("FAIL split_ar: got addr=%h len=%0d, required addr=%h len=%0d",
                             obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512], exp_ar[39:8], exp_ar[7:0]);
                end
                rd_ptr++;
            end
        end
        n_checks++;
        if (rd_ptr != obs_wr || done_count - d0 != 1) begin
            n_fail++;
            $display("FAIL split_count: got %0d extra ARs and %0d done, required 0 and 1",
                     obs_wr - rd_ptr, done_count - d0);
            rd_ptr = obs_wr;
        end
    endtask

    task automatic test_outstanding();
        int d0, h0;
        d0 = done_count;
        h0 = hs_count;
        r_limit = r_sent;
        for (int k = 0; k < 8; k++) exp_q.push_back({32'h0000_2000 + 32'(64 * k), 8'd15});
        start_job(32'h0000_2000, 16'd128, 16'd1);
        tick(30);
        n_checks++;
        if (hs_count - h0 != 4) begin
            n_fail++;
            $display("FAIL outst_limit: got %0d handshakes, required 4", hs_count - h0);
        end
        @(negedge aclk);
        n_checks++;
        if (axi_if.m_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL outst_arvalid: arvalid=%b, required 0", axi_if.m_axi_arvalid);
        end
        tick(1);
        r_limit = r_sent + 1;
        tick(20);
        n_checks++;
        if (hs_count - h0 != 5) begin
            n_fail++;
            $display("FAIL outst_release: got %0d handshakes, required 5", hs_count - h0);
        end
        r_limit = BIG;
        wait_done(d0, 300);
        while (exp_q.size() > 0) begin
            exp_ar = exp_q.pop_front();
            n_checks++;
            if (rd_ptr >= obs_wr) begin
                n_fail++;
                $display("FAIL outst_ar: no AR seen, required addr=%h len=%0d", exp_ar[39:8], exp_ar[7:0]);
            end else begin
                if ({obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512]} !== exp_ar) begin
                    n_fail++;
                    $display("FAIL outst_ar: got addr=%h len=%0d, required addr=%h len=%0d",
                             obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512], exp_ar[39:8], exp_ar[7:0]);
                end
                rd_ptr++;
            end
        end
        n_checks++;
        if (rd_ptr != obs_wr || done_count - d0 != 1) begin
            n_fail++;
            $display("FAIL outst_count: got %0d extra ARs and %0d done, required 0 and 1",
                     obs_wr - rd_ptr, done_count - d0);
            rd_ptr = obs_wr;
        end
    endtask

    task automatic test_backpressure();
        int d0;
        d0 = done_count;
        axi_if.m_axi_arready = 1'b0;
        exp_q.push_back({32'h0000_3000, 8'd15});
        exp_q.push_back({32'h0000_3040, 8'd15});
        start_job(32'h0000_3000, 16'd32, 16'd1);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            n_checks++;
            if (axi_if.m_axi_arvalid !== 1'b1 || axi_if.m_axi_araddr !== 32'h0000_3000 ||
                axi_if.m_axi_arlen !== 8'd15) begin
                n_fail++;
                $display("FAIL stall_hold: arvalid=%b addr=%h len=%0d, required 1/00003000/15",
                         axi_if.m_axi_arvalid, axi_if.m_axi_araddr, axi_if.m_axi_arlen);
            end
            if (i == 3) begin
                @(posedge aclk);
                #1;
                start = 1'b1; start_adr = 32'h0000_9000; xsize = 16'd4; ysize = 16'd1;
            end else if (i == 4) begin
                @(posedge aclk);
                #1;
                start = 1'b0;
            end
        end
        tick(1);
        axi_if.m_axi_arready = 1'b1;
        wait_done(d0, 300);
        while (exp_q.size() > 0) begin
            exp_ar = exp_q.pop_front();
            n_checks++;
            if (rd_ptr >= obs_wr) begin
                n_fail++;
                $display("FAIL stall_ar: no AR seen, required addr=%h len=%0d", exp_ar[39:8], exp_ar[7:0]);
            end else begin
                if ({obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512]} !== exp_ar) begin
                    n_fail++;
                    $display("FAIL stall_ar: got addr=%h len=%0d, required addr=%h len=%0d",
                             obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512], exp_ar[39:8], exp_ar[7:0]);
                end
                rd_ptr++;
            end
        end
        tick(10);
        n_checks++;
        if (rd_ptr != obs_wr || done_count - d0 != 1) begin
            n_fail++;
            $display("FAIL stall_start_ignored: got %0d extra ARs and %0d done, required 0 and 1",
                     obs_wr - rd_ptr, done_count - d0);
            rd_ptr = obs_wr;
        end
    endtask

    task automatic test_zero_size();
        int d0, h0;
        d0 = done_count;
        h0 = hs_count;
        start_job(32'h0000_5000, 16'd0, 16'd5);
        @(negedge aclk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_x_done: done=%b busy=%b, required 1/0", done, busy);
        end
        start_job(32'h0000_5000, 16'd5, 16'd0);
        @(negedge aclk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_y_done: done=%b busy=%b, required 1/0", done, busy);
        end
        tick(5);
        n_checks++;
        if (hs_count - h0 != 0 || done_count - d0 != 2) begin
            n_fail++;
            $display("FAIL zero_totals: got %0d ARs and %0d done, required 0 and 2",
                     hs_count - h0, done_count - d0);
        end
    endtask

    task automatic test_reset_mid_job();
        int d0, h0;
        d0 = done_count;
        h0 = hs_count;
        r_limit = r_sent;
        exp_q.push_back({32'h0000_4000, 8'd15});
        exp_q.push_back({32'h0000_4040, 8'd15});
        start_job(32'h0000_4000, 16'd128, 16'd2);
        for (int c = 0; c < 50; c++) begin
            if (hs_count - h0 >= 2) break;
            tick(1);
        end
        axi_if.m_axi_arready = 1'b0;
        tick(3);
        @(negedge aclk);
        n_checks++;
        if (axi_if.m_axi_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: arvalid=%b, required 1", axi_if.m_axi_arvalid);
        end
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if ({axi_if.m_axi_arvalid, axi_if.m_axi_araddr, axi_if.m_axi_arlen, busy, done} !== 43'd0) begin
            n_fail++;
            $display("FAIL midrst_async: arvalid=%b araddr=%h arlen=%0d busy=%b done=%b, required all 0",
                     axi_if.m_axi_arvalid, axi_if.m_axi_araddr, axi_if.m_axi_arlen, busy, done);
        end
        tick(2);
        areset = 1'b0;
        axi_if.m_axi_arready = 1'b1;
        r_limit = BIG;
        tick(20);
        n_checks++;
        if (done_count != d0 || dbg_state !== RD_IDLE) begin
            n_fail++;
            $display("FAIL midrst_no_done: got %0d done, state %0d, required 0 done, state %0d",
                     done_count - d0, dbg_state, RD_IDLE);
        end
        while (exp_q.size() > 0) begin
            exp_ar = exp_q.pop_front();
            n_checks++;
            if (rd_ptr >= obs_wr) begin
                n_fail++;
                $display("FAIL midrst_ar: no AR seen, required addr=%h len=%0d", exp_ar[39:8], exp_ar[7:0]);
            end else begin
                if ({obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512]} !== exp_ar) begin
                    n_fail++;
                    $display("FAIL midrst_ar: got addr=%h len=%0d, required addr=%h len=%0d",
                             obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512], exp_ar[39:8], exp_ar[7:0]);
                end
                rd_ptr++;
            end
        end
        n_checks++;
        if (rd_ptr != obs_wr) begin
            n_fail++;
            $display("FAIL midrst_extra_ar: got %0d extra ARs, required 0", obs_wr - rd_ptr);
            rd_ptr = obs_wr;
        end
    endtask

    // Wrap past 2^32, then random jobs checked against the reference model.
    task automatic test_random_jobs();
        logic [31:0] base;
        int x, y, d0;
        for (int j = 0; j < 5; j++) begin
            if (j == 0) begin
                base = 32'hFFFF_FFF0; x = 16; y = 2;
            end else begin
                base = $urandom(); x = $urandom_range(1, 40); y = $urandom_range(1, 3);
            end
            d0 = done_count;
            push_model(base, x, y);
            start_job(base, 16'(x), 16'(y));
            wait_done(d0, 600);
            while (exp_q.size() > 0) begin
                exp_ar = exp_q.pop_front();
                n_checks++;
                if (rd_ptr >= obs_wr) begin
                    n_fail++;
                    $display("FAIL rand_ar: job %0d no AR seen, required addr=%h len=%0d",
                             j, exp_ar[39:8], exp_ar[7:0]);
                end else begin
                    if ({obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512]} !== exp_ar) begin
                        n_fail++;
                        $display("FAIL rand_ar: job %0d got addr=%h len=%0d, required addr=%h len=%0d", j,
                                 obs_addr[rd_ptr % 512], obs_len[rd_ptr % 512], exp_ar[39:8], exp_ar[7:0]);
                    end
                    rd_ptr++;
                end
            end
            n_checks++;
            if (rd_ptr != obs_wr || done_count - d0 != 1) begin
                n_fail++;
                $display("FAIL rand_count: job %0d got %0d extra ARs and %0d done, required 0 and 1",
                         j, obs_wr - rd_ptr, done_count - d0);
                rd_ptr = obs_wr;
            end
        end
        n_checks++;
        if (peak_flight > 4) begin
            n_fail++;
            $display("FAIL rand_outstanding: peak %0d in flight, required <= 4", peak_flight);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split(32'h8000_0FF0, 16'd8, 16'd1, 2,
                   {32'h8000_0FF0, 8'd3}, {32'h8000_1000, 8'd3}, 40'd0, 40'd0);
        test_split(32'h0000_1000, 16'd20, 16'd2, 4,
                   {32'h0000_1000, 8'd15}, {32'h0000_1040, 8'd3},
                   {32'h0000_1050, 8'd15}, {32'h0000_1090, 8'd3});
        test_outstanding();
        test_backpressure();
        test_zero_size();
        test_reset_mid_job();
        test_random_jobs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
